rgb_layer_compositor: RTL and testbench

- Parametrised, pipelined successor to the one-hot pixel colour selector in the VGA display path.
- Takes NUM_LAYERS colour sources (board cells, title, mouse, numbers, text, ...) and a per-layer select vector, and resolves one registered pixel colour per pixel tick.
- Adds a per-layer enable mask, a priority mode, video blanking and collision detection/counting.
- Sits between the sprite/text generators and the VGA output register.

---
 rtl/rgb_layer_compositor.sv | 117 +++++++++++
 tb/tb_rgb_layer_compositor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_layer_compositor.sv
// Two-stage layer compositor: resolves one registered pixel colour from NUM_LAYERS sources.
// Latency two pix_tick edges; no backpressure, all state holds while pix_tick=0.
module rgb_layer_compositor #(
   parameter int                NUM_LAYERS = 20,
   parameter int                RGB_W      = 3,
   parameter int                MODE       = 0,
   parameter logic [RGB_W-1:0]  BG_COLOR   = '0,
   parameter logic [RGB_W-1:0]  ERR_COLOR  = '1,
   parameter int                CNT_W      = 16,
   localparam int               IDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        pix_tick,
   input  logic                        video_on,
   input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]       layer_sel,
   input  logic [NUM_LAYERS-1:0]       layer_en,
   input  logic                        clr_cnt,
   output logic [RGB_W-1:0]            rgb_out,
   output logic [IDX_W-1:0]            hit_idx,
   output logic                        hit,
   output logic                        collision,
   output logic [CNT_W-1:0]            coll_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_LAYERS-1:0] eff_sel;
   logic                  vo1_q, n1_q, m1_q;
   logic                  n1_d, m1_d;
   logic [IDX_W-1:0]      idx1_q, idx1_d;
   logic [RGB_W-1:0]      c1_q, c1_d;

   logic [RGB_W-1:0]      rgb_q, rgb_d;
   logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
   logic                  hit_q, hit_d;
   logic                  coll_q, coll_d;
   logic [CNT_W-1:0]      cnt_q;

   // Stage 1: masked select, hit/multi-hit flags and highest-index winner
   always_comb begin
      eff_sel = layer_sel & layer_en;
      n1_d    = |eff_sel;
      m1_d    = |(eff_sel & (eff_sel - NUM_LAYERS'(1)));
      idx1_d  = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (eff_sel[i]) idx1_d = IDX_W'(i);
      end
      c1_d = layer_rgb[int'(idx1_d)*RGB_W +: RGB_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vo1_q  <= 1'b0;
         n1_q   <= 1'b0;
         m1_q   <= 1'b0;
         idx1_q <= '0;
         c1_q   <= '0;
      end else if (pix_tick) begin
         vo1_q  <= video_on;
         n1_q   <= n1_d;
         m1_q   <= m1_d;
         idx1_q <= idx1_d;
         c1_q   <= c1_d;
      end
   end

   // Stage 2: blanking and empty select beat multi-hit, which beats a normal hit
   always_comb begin
      rgb_d     = BG_COLOR;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      if (!vo1_q || !n1_q) begin
         rgb_d = BG_COLOR;
      end else if (m1_q && (MODE == 0)) begin
         rgb_d = ERR_COLOR;
      end else begin
         rgb_d     = c1_q;
         hit_d     = 1'b1;
         hit_idx_d = idx1_q;
      end
      coll_d = vo1_q & m1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q     <= BG_COLOR;
         hit_idx_q <= '0;
         hit_q     <= 1'b0;
         coll_q    <= 1'b0;
      end else if (pix_tick) begin
         rgb_q     <= rgb_d;
         hit_idx_q <= hit_idx_d;
         hit_q     <= hit_d;
         coll_q    <= coll_d;
      end
   end

   // Clear is independent of pix_tick and drops a coincident collision
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_cnt) begin
         cnt_q <= '0;
      end else if (pix_tick && coll_d && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign rgb_out   = rgb_q;
   assign hit_idx   = hit_idx_q;
   assign hit       = hit_q;
   assign collision = coll_q;
   assign coll_cnt  = cnt_q;

endmodule

// File: tb/tb_rgb_layer_compositor.sv
// Directed bench: strict-mode, priority-mode and narrow-counter instances share one stimulus.
module tb_rgb_layer_compositor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_tick;
   logic        video_on;
   logic [59:0] layer_rgb;
   logic [19:0] layer_sel;
   logic [19:0] layer_en;
   logic        clr_cnt;

   logic [2:0]  rgb0, rgb1, rgb2;
   logic [4:0]  idx0, idx1, idx2;
   logic        hit0, hit1, hit2;
   logic        coll0, coll1, coll2;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rgb_layer_compositor #(.NUM_LAYERS(20), .RGB_W(3), .MODE(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .video_on(video_on),
      .layer_rgb(layer_rgb), .layer_sel(layer_sel), .layer_en(layer_en), .clr_cnt(clr_cnt),
      .rgb_out(rgb0), .hit_idx(idx0), .hit(hit0), .collision(coll0), .coll_cnt(cnt0));

   rgb_layer_compositor #(.NUM_LAYERS(20), .RGB_W(3), .MODE(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .video_on(video_on),
      .layer_rgb(layer_rgb), .layer_sel(layer_sel), .layer_en(layer_en), .clr_cnt(clr_cnt),
      .rgb_out(rgb1), .hit_idx(idx1), .hit(hit1), .collision(coll1), .coll_cnt(cnt1));

   rgb_layer_compositor #(.NUM_LAYERS(20), .RGB_W(3), .MODE(0), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .video_on(video_on),
      .layer_rgb(layer_rgb), .layer_sel(layer_sel), .layer_en(layer_en), .clr_cnt(clr_cnt),
      .rgb_out(rgb2), .hit_idx(idx2), .hit(hit2), .collision(coll2), .coll_cnt(cnt2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One stalled pixel tick: three idle clocks then one enabled clock
   task automatic stall_tick(input string tag, input logic [2:0] hold_rgb);
      pix_tick = 1'b0;
      clocks(3);
      chk({tag, "_hold"}, 32'(rgb0), 32'(hold_rgb));
      pix_tick = 1'b1;
      clocks(1);
      pix_tick = 1'b0;
   endtask

   initial begin
      // Reset with random inputs
      rst_n    = 1'b0;
      pix_tick = 1'b1;
      repeat (3) begin
         video_on  = 1'($urandom);
         layer_rgb = {$urandom, $urandom};
         layer_sel = 20'($urandom);
         layer_en  = 20'($urandom);
         clr_cnt   = 1'($urandom);
         clocks(1);
      end
      chk("rst_rgb0",  32'(rgb0),  0);
      chk("rst_hit0",  32'(hit0),  0);
      chk("rst_idx0",  32'(idx0),  0);
      chk("rst_coll0", 32'(coll0), 0);
      chk("rst_cnt0",  32'(cnt0),  0);
      chk("rst_cnt2",  32'(cnt2),  0);

      // Release; first valid pixel needs two ticks
      rst_n    = 1'b1;
      clr_cnt  = 1'b0;
      video_on = 1'b1;
      layer_en = '1;
      for (int i = 0; i < 20; i++) layer_rgb[i*3 +: 3] = 3'(i % 8);
      layer_sel = 20'(1) << 5;
      clocks(1);
      chk("rel_t1_hit0", 32'(hit0), 0);
      chk("rel_t1_rgb0", 32'(rgb0), 0);
      clocks(1);
      chk("rel_t2_rgb0", 32'(rgb0), 5);
      chk("rel_t2_hit0", 32'(hit0), 1);

      // One-hot sweep
      for (int i = 0; i < 20; i++) begin
         layer_sel = 20'(1) << i;
         clocks(2);
         chk("sweep_rgb0",  32'(rgb0),  32'(i % 8));
         chk("sweep_idx0",  32'(idx0),  32'(i));
         chk("sweep_hit0",  32'(hit0),  1);
         chk("sweep_coll0", 32'(coll0), 0);
         chk("sweep_rgb1",  32'(rgb1),  32'(i % 8));
         chk("sweep_idx1",  32'(idx1),  32'(i));
      end
      layer_sel = '0;
      clocks(2);
      chk("none_rgb0", 32'(rgb0), 0);
      chk("none_hit0", 32'(hit0), 0);
      chk("none_hit1", 32'(hit1), 0);

      // Collision on layers 3 and 17
      layer_rgb[3*3 +: 3]  = 3'd5;
      layer_rgb[17*3 +: 3] = 3'd2;
      layer_sel = (20'(1) << 3) | (20'(1) << 17);
      clocks(2);
      chk("col_rgb0",  32'(rgb0),  7);
      chk("col_hit0",  32'(hit0),  0);
      chk("col_coll0", 32'(coll0), 1);
      chk("col_cnt0",  32'(cnt0),  1);
      chk("col_rgb1",  32'(rgb1),  2);
      chk("col_idx1",  32'(idx1),  17);
      chk("col_hit1",  32'(hit1),  1);
      chk("col_coll1", 32'(coll1), 1);
      chk("col_cnt2",  32'(cnt2),  1);

      // Mask layer 17: the stage-1 collision drains once more, then clean
      layer_en[17] = 1'b0;
      clocks(2);
      chk("mask_rgb0",  32'(rgb0),  5);
      chk("mask_idx0",  32'(idx0),  3);
      chk("mask_hit0",  32'(hit0),  1);
      chk("mask_coll0", 32'(coll0), 0);
      chk("mask_cnt0",  32'(cnt0),  2);
      chk("mask_rgb1",  32'(rgb1),  5);

      // Blanking
      layer_en = '1;
      video_on = 1'b0;
      clocks(2);
      chk("blank_rgb0",  32'(rgb0),  0);
      chk("blank_hit0",  32'(hit0),  0);
      chk("blank_coll0", 32'(coll0), 0);
      chk("blank_cnt0",  32'(cnt0),  2);
      chk("blank_hit1",  32'(hit1),  0);

      // Clear with pix_tick low
      video_on = 1'b1;
      pix_tick = 1'b0;
      clr_cnt  = 1'b1;
      clocks(1);
      clr_cnt  = 1'b0;
      chk("clr_idle_cnt0", 32'(cnt0), 0);
      chk("clr_idle_cnt2", 32'(cnt2), 0);

      // Stalled run: pix_tick every 4th clock
      layer_sel = 20'(1) << 2;
      stall_tick("st_a1", 3'd0);
      chk("st_a1_rgb0", 32'(rgb0), 0);
      stall_tick("st_a2", 3'd0);
      chk("st_a2_rgb0", 32'(rgb0), 2);
      chk("st_a2_idx0", 32'(idx0), 2);
      layer_sel = 20'(1) << 9;
      stall_tick("st_b1", 3'd2);
      chk("st_b1_rgb0", 32'(rgb0), 2);
      stall_tick("st_b2", 3'd2);
      chk("st_b2_rgb0", 32'(rgb0), 1);
      chk("st_b2_idx0", 32'(idx0), 9);
      layer_sel = 20'(1) << 19;
      stall_tick("st_c1", 3'd1);
      chk("st_c1_rgb0", 32'(rgb0), 1);
      stall_tick("st_c2", 3'd1);
      chk("st_c2_rgb0", 32'(rgb0), 3);
      chk("st_c2_idx0", 32'(idx0), 19);
      chk("st_cnt0",    32'(cnt0), 0);

      // Counter saturation: 21 collided pixels reach stage 2
      pix_tick  = 1'b1;
      layer_sel = (20'(1) << 3) | (20'(1) << 17);
      clocks(22);
      chk("sat_cnt2", 32'(cnt2), 15);
      chk("sat_cnt0", 32'(cnt0), 21);

      // Clear wins over a coincident collision
      clr_cnt = 1'b1;
      clocks(1);
      clr_cnt = 1'b0;
      chk("clrcol_coll0", 32'(coll0), 1);
      chk("clrcol_cnt2",  32'(cnt2),  0);
      chk("clrcol_cnt0",  32'(cnt0),  0);
      clocks(1);
      chk("after_clr_cnt2", 32'(cnt2), 1);
      chk("after_clr_cnt0", 32'(cnt0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
